// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register-file scoreboard slice.
// Holds the architectural index width and the default geometry.
// Also provides the helper that maps a slot number back to its index.
package regfile_scoreboard_pkg;

    localparam int IDX_W     = 5;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 3;
    localparam int DEF_BASE  = 5;

    // Architectural index of a slot; BASE+NREGS <= 32 keeps this in range
    function automatic logic [IDX_W-1:0] slot_idx(input int base, input int slot);
        return IDX_W'(base + slot);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard check and outstanding-write count.
// issue_ready is combinational from the inputs; busy and pending update one edge later.
// A write-back clearing a slot in the same cycle unblocks that slot immediately.
module rf_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int BASE  = DEF_BASE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_we,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic [IDX_W-1:0] issue_rs1,
    input  logic [IDX_W-1:0] issue_rs2,
    output logic             issue_ready,
    output logic [5:0]       pending
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr_hit;
    logic [NREGS-1:0] set_hit;
    logic [NREGS-1:0] blocked;
    logic [5:0]       pending_q;
    logic [5:0]       pending_d;

    // Hazard check against effectively-busy slots, then next busy set and its popcount
    always_comb begin
        clr_hit   = '0;
        set_hit   = '0;
        blocked   = '0;
        pending_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            clr_hit[i] = wb_we && (wb_rd == slot_idx(BASE, i));
            blocked[i] = busy_q[i] && !clr_hit[i] &&
                         ((issue_rd  == slot_idx(BASE, i)) ||
                          (issue_rs1 == slot_idx(BASE, i)) ||
                          (issue_rs2 == slot_idx(BASE, i)));
        end
        issue_ready = rst_n && (blocked == '0);
        for (int i = 0; i < NREGS; i++) begin
            set_hit[i] = issue_valid && issue_ready && (issue_rd == slot_idx(BASE, i));
        end
        // Set wins over a same-cycle clear
        busy_d = (busy_q & ~clr_hit) | set_hit;
        for (int i = 0; i < NREGS; i++) begin
            if (busy_d[i]) begin
                pending_d = pending_d + 6'd1;
            end
        end
    end

    // Busy bits and registered pending count; reset overrides issue and write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Small windowed register file (indices BASE..BASE+NREGS-1) with scoreboard.
// Read ports have one cycle latency with write-back bypass; all_values is direct.
// issue_ready deasserts on RAW/WAW hazards against outstanding writes.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int BASE  = DEF_BASE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_we,
    input  logic [IDX_W-1:0]       wb_rd,
    input  logic [WIDTH-1:0]       wb_value,
    input  logic [IDX_W-1:0]       rs1_addr,
    input  logic [IDX_W-1:0]       rs2_addr,
    output logic [WIDTH-1:0]       rs1_data,
    output logic [WIDTH-1:0]       rs2_data,
    input  logic                   issue_valid,
    input  logic [IDX_W-1:0]       issue_rd,
    input  logic [IDX_W-1:0]       issue_rs1,
    input  logic [IDX_W-1:0]       issue_rs2,
    output logic                   issue_ready,
    output logic [5:0]             pending,
    output logic [NREGS*WIDTH-1:0] all_values
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] rs1_data_q;
    logic [WIDTH-1:0] rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q;
    logic [WIDTH-1:0] rs2_data_d;

    // Slot writes and read muxes; bypass only applies to mapped addresses,
    // so an unmapped read always returns 0
    always_comb begin
        rs1_data_d = '0;
        rs2_data_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_we && (wb_rd == slot_idx(BASE, i))) begin
                regs_d[i] = wb_value;
            end
            if (rs1_addr == slot_idx(BASE, i)) begin
                rs1_data_d = regs_d[i];
            end
            if (rs2_addr == slot_idx(BASE, i)) begin
                rs2_data_d = regs_d[i];
            end
        end
    end

    // Data array and registered read ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;

    // Flat dump of register contents
    for (genvar g = 0; g < NREGS; g++) begin : g_dump
        assign all_values[g*WIDTH +: WIDTH] = regs_q[g];
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .BASE  (BASE)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .pending     (pending)
    );

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 3, range 1..32, giving the number of implemented registers.
REQ-003 The block SHALL have parameter BASE, default 5, giving the architectural index of register 0; BASE+NREGS SHALL be at most 32.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 wb_we  in  1  write-back enable.
REQ-007 wb_rd  in  5  write-back architectural index.
REQ-008 wb_value  in  WIDTH  write-back data.
REQ-009 rs1_addr, rs2_addr  in  5 each  read-port architectural indices.
REQ-010 rs1_data, rs2_data  out  WIDTH each  registered read data.
REQ-011 issue_valid  in  1  an instruction requests issue.
REQ-012 issue_rd, issue_rs1, issue_rs2  in  5 each  destination and source indices of the issuing instruction.
REQ-013 issue_ready  out  1  issue accepted this cycle when high together with issue_valid.
REQ-014 pending  out  6  count of registers with a write outstanding.
REQ-015 all_values  out  NREGS*WIDTH  flat dump; register i occupies bits [i*WIDTH +: WIDTH].

Function
REQ-016 An index a is "mapped" iff BASE <= a < BASE+NREGS; its slot is a-BASE.
REQ-017 When wb_we=1 and wb_rd is mapped, the slot SHALL take wb_value at the clock edge; an unmapped wb_rd SHALL change no state.
REQ-018 rs1_data and rs2_data SHALL have a latency of one cycle: each is sampled at the edge from the register addressed by its address input in the previous cycle.
REQ-019 An unmapped read address SHALL return 0.
REQ-020 Bypass: if wb_we=1 and wb_rd equals a read address in the same cycle, that port SHALL return wb_value rather than the old content.
REQ-021 all_values SHALL reflect register contents directly, with no extra latency beyond the write edge.
REQ-022 Each slot SHALL have a busy bit; a bit is "effectively busy" when it is set and is not being cleared by a write-back in the current cycle.
REQ-023 issue_ready SHALL be 1 iff rst_n=1 and no mapped index among issue_rd, issue_rs1, issue_rs2 is effectively busy (RAW and WAW hazard check); unmapped indices never block.
REQ-024 On issue_valid & issue_ready with issue_rd mapped, busy[issue_rd] SHALL be set at the edge.
REQ-025 A write-back with wb_we=1 and wb_rd mapped SHALL clear busy[wb_rd] at the edge.
REQ-026 If a set and a clear target the same slot in the same cycle, the set SHALL win and the bit stays busy.
REQ-027 pending SHALL equal the population count of the busy bits after the edge; its maximum is NREGS.
REQ-028 A write-back to a slot that is not busy SHALL still update data and SHALL leave busy at 0.

Reset
REQ-029 While rst_n=0 at an edge, all registers SHALL be cleared to 0, all busy bits to 0, rs1_data and rs2_data to 0, and pending to 0.
REQ-030 Reset SHALL take priority over simultaneous write-back and issue, including mid-operation with writes outstanding.
REQ-031 issue_ready SHALL be 0 while rst_n=0.

Structure
REQ-032 A shared package SHALL hold the 5-bit register-index width constant and the default values for WIDTH, NREGS and BASE.
REQ-033 Hazard detection and busy-bit storage SHALL be one sub-module, rf_scoreboard; the data array and read ports SHALL stay in the top module.

Verification
REQ-034 Reset then write idx 5=0xDEADBEEF; read rs1=5 on the next cycle -> rs1_data=0xDEADBEEF one cycle later, all_values[31:0]=0xDEADBEEF.
REQ-035 Same-cycle wb_we=1 with wb_rd=6, value 0x1234, and rs2_addr=6 -> next-cycle rs2_data=0x1234.
REQ-036 Issue rd=7 -> pending=1; an issue with rs1=7 -> issue_ready=0; write-back to 7 in the same cycle as a rs1=7 request -> issue_ready=1.
REQ-037 Same-cycle write-back to 5 and issue with rd=5 while 5 is busy -> busy stays set, pending unchanged.
REQ-038 Write to idx 4 and idx 8 with NREGS=3, BASE=5 -> no state change; read of 4 -> 0; issue with rd=31 -> ready=1 and pending unchanged.
REQ-039 Three outstanding issues, then rst_n=0 for one edge -> pending=0, all_values=0, issue_ready=1 after release.
